// File: rtl/axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_reg_slave
// Purpose  : AXI4-Lite slave exposing NUM_REGS byte-strobed registers of
//            DATA_W bits. Write and read channels run independently. The
//            AW and W beats may arrive in any order or in the same cycle.
//            An access whose word index is >= NUM_REGS gets SLVERR and
//            leaves storage untouched. Such a read returns zero.
// Ports    : aclk, aresetn             clock, async active-low reset
//            awaddr/awprot/awvalid/awready        write address channel
//            wdata/wstrb/wvalid/wready            write data channel
//            bresp/bvalid/bready                  write response channel
//            araddr/arprot/arvalid/arready        read address channel
//            rdata/rresp/rvalid/rready            read data channel
// Revision : 1.0  initial release
// ============================================================================
module axi_lite_reg_slave #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 7,
  parameter int NUM_REGS = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic [2:0]            awprot,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic [2:0]            arprot,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int              c_STRB_W      = DATA_W / 8;
  localparam int              c_LSB         = $clog2(c_STRB_W);
  localparam int              c_IDX_W       = ADDR_W - c_LSB;
  // One extra bit so that NUM_REGS == 2**c_IDX_W is representable.
  localparam logic [c_IDX_W:0] c_NUM_REGS   = (c_IDX_W + 1)'(NUM_REGS);
  localparam logic [1:0]      c_RESP_OKAY   = 2'b00;
  localparam logic [1:0]      c_RESP_SLVERR = 2'b10;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic                r_aw_held;
  logic [c_IDX_W-1:0]  r_aw_idx;
  logic                r_w_held;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_STRB_W-1:0] r_wstrb;
  logic                r_bvalid;
  logic [1:0]          r_bresp;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rresp;

  logic                w_awready;
  logic                w_wready;
  logic                w_aw_fire;
  logic                w_w_fire;
  logic                w_commit;
  logic [c_IDX_W-1:0]  w_wr_idx;
  logic [DATA_W-1:0]   w_wr_data;
  logic [c_STRB_W-1:0] w_wr_strb;
  logic                w_wr_in_range;
  logic                w_ar_fire;
  logic [c_IDX_W-1:0]  w_rd_idx;
  logic                w_rd_in_range;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_unused;

  // Protection bits and sub-word address bits carry no meaning here.
  assign w_unused = ^{awprot, arprot, awaddr[c_LSB-1:0], araddr[c_LSB-1:0]};

  // --------------------------------------------------------------------------
  // Write path
  // --------------------------------------------------------------------------
  // Both address and data are refused while a response is outstanding. So a
  // new transaction can never overtake an unacknowledged one.
  assign w_awready = ~r_aw_held & ~r_bvalid;
  assign w_wready  = ~r_w_held  & ~r_bvalid;
  assign w_aw_fire = awvalid & w_awready;
  assign w_w_fire  = wvalid  & w_wready;

  // Commit as soon as both halves are either already held or arriving now.
  // The live bus value is used when it is arriving this cycle.
  assign w_commit  = (r_aw_held | w_aw_fire) & (r_w_held | w_w_fire);
  assign w_wr_idx  = r_aw_held ? r_aw_idx : awaddr[ADDR_W-1:c_LSB];
  assign w_wr_data = r_w_held  ? r_wdata  : wdata;
  assign w_wr_strb = r_w_held  ? r_wstrb  : wstrb;
  assign w_wr_in_range = ({1'b0, w_wr_idx} < c_NUM_REGS);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_held <= 1'b0;
      r_aw_idx  <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= c_RESP_OKAY;
    end else begin
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
      end else begin
        if (w_aw_fire) begin
          r_aw_held <= 1'b1;
          r_aw_idx  <= awaddr[ADDR_W-1:c_LSB];
        end
        if (w_w_fire) begin
          r_w_held <= 1'b1;
          r_wdata  <= wdata;
          r_wstrb  <= wstrb;
        end
        if (r_bvalid && bready) begin
          r_bvalid <= 1'b0;
        end
      end
    end
  end

  // Register storage. An out-of-range index matches no register, so it
  // naturally writes nothing.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
    end else if (w_commit) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_wr_idx == c_IDX_W'(r)) begin
          for (int b = 0; b < c_STRB_W; b++) begin
            if (w_wr_strb[b]) begin
              r_regs[r][8*b +: 8] <= w_wr_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  assign w_ar_fire     = arvalid & ~r_rvalid;
  assign w_rd_idx      = araddr[ADDR_W-1:c_LSB];
  assign w_rd_in_range = ({1'b0, w_rd_idx} < c_NUM_REGS);

  // The mux reads the current register contents. A read that lands on the
  // same edge as a write commit therefore returns the pre-write value.
  always_comb begin
    w_rd_data = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (w_rd_idx == c_IDX_W'(r)) begin
        w_rd_data = r_regs[r];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= c_RESP_OKAY;
    end else if (w_ar_fire) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_in_range ? c_RESP_OKAY : c_RESP_SLVERR;
    end else if (r_rvalid && rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign awready = w_awready;
  assign wready  = w_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign arready = ~r_rvalid;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_reg_slave
// Purpose  : Self-checking bench for axi_lite_reg_slave with default
//            parameters (32-bit data, 7-bit address, 16 registers).
//            Expected responses are queued when stimulus is issued. They
//            are compared when the DUT presents them.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_lite_reg_slave;

  localparam int c_DATA_W = 32;
  localparam int c_ADDR_W = 7;
  localparam int c_NREGS  = 16;

  logic                  aclk = 1'b0;
  logic                  aresetn;
  logic [c_ADDR_W-1:0]   awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [c_DATA_W-1:0]   wdata;
  logic [c_DATA_W/8-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [c_ADDR_W-1:0]   araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [c_DATA_W-1:0]   rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  axi_lite_reg_slave #(
    .DATA_W   (c_DATA_W),
    .ADDR_W   (c_ADDR_W),
    .NUM_REGS (c_NREGS)
  ) u_dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .awaddr  (awaddr),
    .awprot  (awprot),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arprot  (arprot),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  always #5 aclk = ~aclk;

  int n_total = 0;
  int n_bad   = 0;

  logic [1:0]  bq[$];
  logic [31:0] rq_data[$];
  logic [1:0]  rq_resp[$];
  logic [31:0] model [c_NREGS];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] exp_resp(input logic [6:0] addr);
    return (int'(addr >> 2) < c_NREGS) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] model_rd(input logic [6:0] addr);
    int idx = int'(addr >> 2);
    return (idx < c_NREGS) ? model[idx] : 32'h0;
  endfunction

  task automatic model_wr(input logic [6:0] addr, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(addr >> 2);
    if (idx < c_NREGS)
      for (int b = 0; b < 4; b++)
        if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  // ---------------- response monitor ----------------
  always @(negedge aclk) begin
    if (bvalid && bready) begin
      if (bq.size() == 0) chk("b_unexpected", 1, 0);
      else chk("bresp", bresp, bq.pop_front());
    end
    if (rvalid && rready) begin
      if (rq_data.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        chk("rdata", rdata, rq_data.pop_front());
        chk("rresp", rresp, rq_resp.pop_front());
      end
    end
  end

  // ---------------- stimulus tasks (entered and left at posedge+1) ----------------
  task automatic do_write(input logic [6:0] addr, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly);
    int  cyc = 0;
    bit  aw_done = 0, w_done = 0, aw_hs, w_hs;
    bq.push_back(exp_resp(addr));
    model_wr(addr, d, s);
    awaddr = addr; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done  && (cyc >= w_dly);
      @(negedge aclk);
      if (!aw_done && cyc < aw_dly) chk("awready_idle", awready, 1);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge aclk); #1;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    chk("write_accept_timeout", {aw_done, w_done}, 2'b11);
    @(negedge aclk);
    chk("b_latency", bvalid, 1);
    @(posedge aclk); #1;
  endtask

  task automatic do_read(input logic [6:0] addr, input logic [31:0] exp_d, input logic [1:0] exp_r);
    int cyc = 0;
    bit done = 0;
    rq_data.push_back(exp_d);
    rq_resp.push_back(exp_r);
    araddr = addr;
    while (!done && cyc < 40) begin
      arvalid = 1;
      @(negedge aclk);
      done = arready;
      @(posedge aclk); #1;
      cyc++;
    end
    arvalid = 0;
    chk("read_accept_timeout", done, 1);
    @(negedge aclk);
    chk("r_latency", rvalid, 1);
    @(posedge aclk); #1;
  endtask

  task automatic rd(input logic [6:0] addr);
    do_read(addr, model_rd(addr), exp_resp(addr));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((bq.size() != 0 || rq_data.size() != 0) && n < 50) begin
      @(posedge aclk); #1;
      n++;
    end
    chk("drain", (bq.size() == 0 && rq_data.size() == 0), 1);
  endtask

  initial begin
    logic [31:0] pre;
    for (int i = 0; i < c_NREGS; i++) model[i] = '0;
    aresetn = 0; awaddr = '0; awprot = 3'b010; awvalid = 0;
    wdata = '0; wstrb = '0; wvalid = 0; bready = 1;
    araddr = '0; arprot = 3'b001; arvalid = 0; rready = 1;

    // Reset state
    repeat (3) @(negedge aclk);
    chk("rst_awready", awready, 1);
    chk("rst_wready",  wready,  1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid",  bvalid,  0);
    chk("rst_rvalid",  rvalid,  0);
    chk("rst_rdata",   rdata,   0);
    @(posedge aclk); #1;
    aresetn = 1;
    @(posedge aclk); #1;

    // Basic write/read
    do_write(7'h08, 32'hDEADBEEF, 4'hF, 0, 0); wait_drain();
    rd(7'h08); wait_drain();

    // W three cycles ahead of AW
    do_write(7'h04, 32'h12345678, 4'hF, 3, 0); wait_drain();
    rd(7'h04); wait_drain();

    // Partial strobes over an all-ones register
    do_write(7'h00, 32'hFFFFFFFF, 4'hF, 0, 0); wait_drain();
    do_write(7'h00, 32'h00000000, 4'h5, 0, 0); wait_drain();
    do_read(7'h00, 32'hFF00FF00, 2'b00); wait_drain();

    // AW ahead of W, upper half only
    do_write(7'h10, 32'hA5A5C3C3, 4'hC, 0, 2); wait_drain();
    rd(7'h10); wait_drain();

    // All-zero strobe modifies nothing
    do_write(7'h08, 32'h11111111, 4'h0, 0, 0); wait_drain();
    do_read(7'h08, 32'hDEADBEEF, 2'b00); wait_drain();

    // Out of range, low address bits ignored, full register sweep
    do_write(7'h40, 32'hCAFEF00D, 4'hF, 0, 0); wait_drain();
    do_read(7'h40, 32'h0, 2'b10); wait_drain();
    rd(7'h7F); wait_drain();
    rd(7'h0B); wait_drain();
    for (int i = 0; i < c_NREGS; i++) begin
      rd(7'(i * 4)); wait_drain();
    end

    // Read on the same edge as a write commit returns the old value
    pre = model_rd(7'h04);
    fork
      do_write(7'h04, 32'h0BADF00D, 4'hF, 0, 0);
      do_read(7'h04, pre, 2'b00);
    join
    wait_drain();
    rd(7'h04); wait_drain();

    // Back-pressure on both response channels
    bready = 0; rready = 0;
    do_write(7'h0C, 32'h55AA55AA, 4'hF, 0, 0);
    do_read(7'h0C, 32'h55AA55AA, 2'b00);
    awvalid = 1; wvalid = 1; arvalid = 1; awaddr = 7'h14; araddr = 7'h14;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk("stall_bvalid",  bvalid,  1);
      chk("stall_bresp",   bresp,   0);
      chk("stall_rvalid",  rvalid,  1);
      chk("stall_rdata",   rdata,   32'h55AA55AA);
      chk("stall_rresp",   rresp,   0);
      chk("stall_awready", awready, 0);
      chk("stall_wready",  wready,  0);
      chk("stall_arready", arready, 0);
    end
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    bready = 1; rready = 1;
    wait_drain();

    // Reset after AW accepted, before W
    awaddr = 7'h18; awvalid = 1;
    @(negedge aclk);
    chk("rst_mid_awready", awready, 1);
    @(posedge aclk); #1;
    awvalid = 0;
    aresetn = 0;
    for (int i = 0; i < c_NREGS; i++) model[i] = '0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    @(negedge aclk);
    chk("post_rst_awready", awready, 1);
    chk("post_rst_wready",  wready,  1);
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk("post_rst_bvalid", bvalid, 0);
    end
    @(posedge aclk); #1;
    rd(7'h18); wait_drain();
    rd(7'h08); wait_drain();
    rd(7'h0C); wait_drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/axi_lite_reg_slave.md
AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 Parameter DATA_W, default 32, data bus width in bits; SHALL be 32 or 64.
REQ-002 Parameter ADDR_W, default 7, byte-address width.
REQ-003 Parameter NUM_REGS, default 16, number of implemented registers; SHALL be at most 2^(ADDR_W - log2(DATA_W/8)).
REQ-004 Ports, one per line (name, direction, width, meaning):
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset; asynchronous, active-low.
- awaddr  in  ADDR_W  write byte address.
- awprot  in  3  write protection; accepted and ignored.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  write byte strobes.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  ADDR_W  read byte address.
- arprot  in  3  read protection; accepted and ignored.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DATA_W  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.

Function
REQ-005 Register index SHALL be addr[ADDR_W-1 : log2(DATA_W/8)]; low address bits are ignored.
REQ-006 An index >= NUM_REGS is out of range: it SHALL produce response SLVERR (2'b10) and SHALL leave storage unmodified. In-range accesses SHALL respond OKAY (2'b00).
REQ-007 Write and read channels SHALL operate independently and concurrently; neither waits on the other.
REQ-008 Write address capture: awready = ~aw_held & ~bvalid; on awvalid&awready, awaddr SHALL be latched and aw_held set.
REQ-009 Write data capture: wready = ~w_held & ~bvalid; on wvalid&wready, wdata and wstrb SHALL be latched and w_held set.
REQ-010 AW and W SHALL be accepted in either order or in the same cycle, with any gap between them.
REQ-011 Write commit occurs at the first clock edge where both AW and W are held or handshaking. At that edge:
- each byte lane i with wstrb[i]=1 is written (in range only);
- lanes with wstrb[i]=0 keep their value;
- aw_held and w_held clear;
- bvalid rises, with bresp valid, in the following cycle.
REQ-012 bvalid and bresp SHALL hold stable until bready; the handshake clears bvalid. Back-to-back writes SHALL sustain one transaction per 2 cycles when bready is held high.
REQ-013 Read: arready = ~rvalid. On arvalid&arready, the addressed register (or 0 if out of range) SHALL be sampled into rdata and rresp; rvalid rises next cycle (latency 1).
REQ-014 rdata, rresp and rvalid SHALL hold stable until rready; the handshake clears rvalid.
REQ-015 A read handshake at the same edge as a write commit to the same register SHALL return the pre-write value.
REQ-016 wstrb all zero SHALL complete the transaction with OKAY (or SLVERR if out of range) and modify nothing.

Reset
REQ-017 While aresetn is low, all storage, rdata, bresp, rresp, bvalid, rvalid, aw_held and w_held SHALL be 0. awready, wready and arready SHALL be 1.
REQ-018 Reset asserted mid-transaction SHALL abandon it: held AW/W is discarded and pending responses are dropped, with no partial write.

Verification
REQ-019 Write 0xDEADBEEF to 0x08 (strb 0xF), then read 0x08 -> bresp 0, bvalid 1 cycle after commit; rdata 0xDEADBEEF, rresp 0, rvalid 1 cycle after AR handshake.
REQ-020 W presented 3 cycles before AW, write 0x12345678 to 0x04 -> awready stays high until AW; exactly one bvalid; readback 0x12345678.
REQ-021 Reg 0x00 = 0xFFFFFFFF, write 0x00000000 with strb 0x5 -> readback 0xFF00FF00.
REQ-022 Write to 0x40 and read 0x40 (NUM_REGS=16, DATA_W=32) -> bresp 2'b10, rresp 2'b10, rdata 0; all registers unchanged.
REQ-023 bready and rready held low 5 cycles -> bvalid, rvalid, bresp, rresp, rdata stable; awready=wready=0 and arready=0 throughout the stall.
REQ-024 aresetn pulsed low after AW accepted but before W -> bvalid never rises; target register reads 0; awready=1 on the first cycle after release.
